if_stage_ctrl: RTL and testbench

IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

---
 rtl/if_stage_ctrl_pkg.sv | 14 +
 rtl/if_stage_ctrl_sat_counter.sv | 27 ++
 rtl/if_stage_ctrl.sv | 122 ++++++++++++
 tb/tb_if_stage_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/if_stage_ctrl_pkg.sv
// Fetch-stage control constants: FSM encoding, default fetch timeout, wait counter width.
// No logic here; shared by the fetch controller and its counters.
package if_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } if_state_t;

    localparam int IF_TIMEOUT_DEF = 15;
    localparam int IF_WAIT_W      = 4;

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async active-high reset.
// Count visible one cycle after the increment; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch handshake controller: drives PC/IF-ID enables from memory ready and hazards.
// Enables are combinational from state and inputs; load-use stall freezes fetch and PC.
module if_stage_ctrl
    import if_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = IF_TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic             lw_stall,
    input  logic             redirect_D,
    output logic             imem_start,
    output logic             EnPC,
    output logic             EnD,
    output logic             ClrD,
    output logic             imem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    if_state_t              r_state;
    if_state_t              w_state_nxt;
    logic                   w_redir;
    logic                   w_wait_inc;
    logic                   w_wait_clr;
    logic [IF_WAIT_W-1:0]   w_wait;
    logic                   r_err;

    assign w_redir = redirect_D & ~lw_stall;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect during ISSUE makes the fetch just launched wrong-path.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ISSUE:   w_state_nxt = w_redir ? ST_DISCARD : ST_FETCH;
            ST_FETCH: begin
                if (!lw_stall) begin
                    if (imem_ready)      w_state_nxt = ST_ISSUE;
                    else if (redirect_D) w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (!lw_stall && imem_ready) w_state_nxt = ST_ISSUE;
            end
            default:    w_state_nxt = ST_ISSUE;
        endcase
    end

    always_comb begin
        imem_start = 1'b0;
        EnPC       = 1'b0;
        EnD        = 1'b0;
        ClrD       = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_ISSUE: begin
                    imem_start = 1'b1;
                    ClrD       = ~lw_stall;
                    EnPC       = w_redir;
                end
                ST_FETCH: begin
                    if (!lw_stall) begin
                        if (redirect_D) begin
                            EnPC = 1'b1;
                            ClrD = 1'b1;
                        end else if (imem_ready) begin
                            EnPC = 1'b1;
                            EnD  = 1'b1;
                        end else begin
                            ClrD = 1'b1;
                        end
                    end
                end
                ST_DISCARD: begin
                    ClrD = ~lw_stall;
                    EnPC = w_redir;
                end
                default: ;
            endcase
        end
    end

    assign w_wait_inc = (r_state != ST_ISSUE) & ~imem_ready;
    assign w_wait_clr = imem_ready | (r_state == ST_ISSUE);

    sat_counter #(.W(IF_WAIT_W)) u_wait_cnt (
        .CLK   (CLK),
        .reset (reset),
        .i_inc (w_wait_inc),
        .i_clr (w_wait_clr),
        .o_cnt (w_wait)
    );

    // Flag is set on the edge where the wait count reaches TIMEOUT; fetch keeps waiting.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_wait_inc && (w_wait == IF_WAIT_W'(TIMEOUT - 1))) begin
            r_err <= 1'b1;
        end
    end

    assign imem_err = r_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .reset (reset),
        .i_inc (~EnD),
        .i_clr (1'b0),
        .o_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: fetch pacing, waits, redirect discard, stalls, timeout, saturation, async reset.
module tb_if_stage_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       imem_ready = 1'b0;
    logic       lw_stall = 1'b0;
    logic       redirect_D = 1'b0;
    logic       imem_start;
    logic       EnPC;
    logic       EnD;
    logic       ClrD;
    logic       imem_err;
    logic [3:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    if_stage_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .imem_ready (imem_ready),
        .lw_stall   (lw_stall),
        .redirect_D (redirect_D),
        .imem_start (imem_start),
        .EnPC       (EnPC),
        .EnD        (EnD),
        .ClrD       (ClrD),
        .imem_err   (imem_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control nibble is {imem_start, EnPC, EnD, ClrD}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, imem_start, EnPC, EnD, ClrD}, {28'd0, exp});
    endtask

    task automatic cyc(input logic rdy, input logic stl, input logic rdr);
        @(negedge CLK);
        reset      = 1'b0;
        imem_ready = rdy;
        lw_stall   = stl;
        redirect_D = rdr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset      = 1'b1;
        imem_ready = 1'b0;
        lw_stall   = 1'b0;
        redirect_D = 1'b0;
        #1;
        chk_ctl("rst_ctl", 4'b0000);
        chk("rst_err", {31'd0, imem_err}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Back-to-back fetches: one instruction every two cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk_ctl("a_issue", 4'b1001);
            chk("a_cnt_issue", {28'd0, stall_cnt}, i);
            cyc(1, 0, 0);
            chk_ctl("a_fetch", 4'b0110);
            chk("a_cnt_fetch", {28'd0, stall_cnt}, i + 1);
        end
        chk("a_err", {31'd0, imem_err}, 32'd0);

        // Memory answers three cycles late.
        do_reset();
        cyc(0, 0, 0);
        chk_ctl("b_issue", 4'b1001);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk_ctl("b_wait", 4'b0001);
        end
        cyc(1, 0, 0);
        chk_ctl("b_take", 4'b0110);
        chk("b_cnt", {28'd0, stall_cnt}, 32'd4);

        // Redirect while waiting: returned word is dropped.
        do_reset();
        cyc(0, 0, 0);
        chk_ctl("c_issue", 4'b1001);
        cyc(0, 0, 1);
        chk_ctl("c_redir", 4'b0101);
        cyc(0, 0, 0);
        chk_ctl("c_discard", 4'b0001);
        cyc(1, 0, 0);
        chk_ctl("c_drop", 4'b0001);
        cyc(0, 0, 0);
        chk_ctl("c_reissue", 4'b1001);

        // Load-use stall masks a redirect and a ready word.
        do_reset();
        cyc(1, 0, 0);
        chk_ctl("d_issue", 4'b1001);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 1);
            chk_ctl("d_hold", 4'b0000);
        end
        cyc(1, 0, 1);
        chk_ctl("d_release", 4'b0101);
        cyc(1, 0, 0);
        chk_ctl("d_reissue", 4'b1001);

        // Fetch timeout: error registers at the end of the 15th wait cycle and sticks.
        do_reset();
        cyc(0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0);
            chk("e_err_wait", {31'd0, imem_err}, (k == 16) ? 32'd1 : 32'd0);
        end
        cyc(1, 0, 0);
        chk_ctl("e_take", 4'b0110);
        chk("e_err_take", {31'd0, imem_err}, 32'd1);
        cyc(1, 0, 0);
        chk("e_err_sticky", {31'd0, imem_err}, 32'd1);
        do_reset();

        // Stall counter saturates at 15, then async reset mid-fetch.
        cyc(0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0);
            chk("f_cnt", {28'd0, stall_cnt}, (k < 15) ? k : 15);
        end
        #2;
        reset = 1'b1;
        #1;
        chk_ctl("f_async_ctl", 4'b0000);
        chk("f_async_err", {31'd0, imem_err}, 32'd0);
        chk("f_async_cnt", {28'd0, stall_cnt}, 32'd0);
        cyc(1, 0, 0);
        chk_ctl("f_post_issue", 4'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
